// File: rtl/portal_msg_arbiter.sv
// Round-robin arbiter sharing the msgSource channel among NUM_REQ portal requesters.
// A grant is held for a whole message, sized by the length field of its header beat.
module portal_msg_arbiter #(
  parameter int unsigned NUM_REQ    = 4,
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic                          CLK,
  input  logic                          RST_N,
  input  logic [NUM_REQ-1:0]            req_src_rdy,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_beat,
  output logic [NUM_REQ-1:0]            req_dst_rdy_b,
  output logic                          msgSource_src_rdy,
  output logic [DATA_WIDTH-1:0]         msgSource_beat,
  input  logic                          msgSource_dst_rdy_b,
  output logic                          busy,
  output logic [$clog2(NUM_REQ)-1:0]    grant_idx,
  output logic [31:0]                   msg_count
);

  localparam int unsigned IdxW = $clog2(NUM_REQ);
  localparam int unsigned LenW = 16;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] HDR  = 2'd1;
  localparam logic [1:0] BODY = 2'd2;

  logic [1:0]      state;
  logic [1:0]      stateNext;
  logic [IdxW-1:0] rrPtr;
  logic [IdxW-1:0] rrPtrNext;
  logic [IdxW-1:0] grantNext;
  logic [LenW-1:0] remaining;
  logic [LenW-1:0] remainingNext;
  logic [31:0]     msgCountNext;
  logic            granted;
  logic            xfer;
  logic            msgEnd;
  logic            winFound;
  logic [IdxW-1:0] winIdx;
  logic [LenW-1:0] hdrLen;

  // Modulo-NUM_REQ add; both operands are already below NUM_REQ.
  function automatic logic [IdxW-1:0] wrapAdd(input logic [IdxW-1:0] base,
                                               input int unsigned     off);
    int unsigned sum;
    sum = 32'(base) + off;
    if (sum >= NUM_REQ) sum = sum - NUM_REQ;
    return IdxW'(sum);
  endfunction

  assign granted = (state != IDLE);

  // Pass-through datapath steered by the held grant.
  always_comb begin
    msgSource_beat    = req_beat[DATA_WIDTH-1:0];
    msgSource_src_rdy = 1'b0;
    req_dst_rdy_b     = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (IdxW'(i) == grant_idx) begin
        msgSource_beat    = req_beat[i*DATA_WIDTH +: DATA_WIDTH];
        msgSource_src_rdy = granted & req_src_rdy[i];
        req_dst_rdy_b[i]  = granted & msgSource_dst_rdy_b;
      end
    end
  end

  assign xfer = msgSource_src_rdy & msgSource_dst_rdy_b;

  // A zero length field still carries the header itself.
  assign hdrLen = (msgSource_beat[LenW-1:0] == '0) ? LenW'(1) : msgSource_beat[LenW-1:0];

  // First requesting index at or after rrPtr, wrapping.
  always_comb begin
    winFound = 1'b0;
    winIdx   = rrPtr;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      if (!winFound && req_src_rdy[wrapAdd(rrPtr, k)]) begin
        winFound = 1'b1;
        winIdx   = wrapAdd(rrPtr, k);
      end
    end
  end

  always_comb begin
    stateNext     = state;
    rrPtrNext     = rrPtr;
    grantNext     = grant_idx;
    remainingNext = remaining;
    msgCountNext  = msg_count;
    msgEnd        = 1'b0;
    case (state)
      IDLE: begin
        if (winFound) begin
          grantNext = winIdx;
          stateNext = HDR;
        end
      end
      HDR: begin
        if (xfer) begin
          if (hdrLen == LenW'(1)) begin
            msgEnd = 1'b1;
          end else begin
            remainingNext = hdrLen - LenW'(1);
            stateNext     = BODY;
          end
        end
      end
      BODY: begin
        if (xfer) begin
          remainingNext = remaining - LenW'(1);
          if (remaining == LenW'(1)) msgEnd = 1'b1;
        end
      end
      default: stateNext = IDLE;
    endcase
    if (msgEnd) begin
      stateNext    = IDLE;
      rrPtrNext    = wrapAdd(grant_idx, 1);
      msgCountNext = msg_count + 32'd1;
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state     <= IDLE;
      rrPtr     <= '0;
      grant_idx <= '0;
      remaining <= '0;
      msg_count <= '0;
      busy      <= 1'b0;
    end else begin
      state     <= stateNext;
      rrPtr     <= rrPtrNext;
      grant_idx <= grantNext;
      remaining <= remainingNext;
      msg_count <= msgCountNext;
      busy      <= (stateNext != IDLE);
    end
  end

endmodule

// File: tb/tb_portal_msg_arbiter.sv
// Bench for portal_msg_arbiter: vector table, directed corners and a message-level
// reference model fed with random traffic.
module tb_portal_msg_arbiter;

  localparam int NREQ = 4;
  localparam int DW   = 32;

  logic              CLK;
  logic              RST_N;
  logic [NREQ-1:0]   req_src_rdy;
  logic [NREQ*DW-1:0] req_beat;
  logic [NREQ-1:0]   req_dst_rdy_b;
  logic              msgSource_src_rdy;
  logic [DW-1:0]     msgSource_beat;
  logic              msgSource_dst_rdy_b;
  logic              busy;
  logic [1:0]        grant_idx;
  logic [31:0]       msg_count;

  portal_msg_arbiter #(.NUM_REQ(NREQ), .DATA_WIDTH(DW)) dut (
    .CLK                 (CLK),
    .RST_N               (RST_N),
    .req_src_rdy         (req_src_rdy),
    .req_beat            (req_beat),
    .req_dst_rdy_b       (req_dst_rdy_b),
    .msgSource_src_rdy   (msgSource_src_rdy),
    .msgSource_beat      (msgSource_beat),
    .msgSource_dst_rdy_b (msgSource_dst_rdy_b),
    .busy                (busy),
    .grant_idx           (grant_idx),
    .msg_count           (msg_count)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int nPass = 0;
  int nChecks = 0;

  // Message-level model: per-requester beat queues and message lengths.
  logic [31:0] beatQ [NREQ][$];
  int          lenQ  [NREQ][$];
  int          grantLog[$];
  int          xferCnt [NREQ];
  bit          mBusy;
  int          mGrant;
  int          mPtr;
  int          mLeft;
  logic [31:0] mCount;

  typedef struct {
    logic [3:0]  src;
    logic [31:0] b0;
    logic [31:0] b2;
    logic        dst;
    logic        eSrc;
    logic [31:0] eBeat;
    logic [3:0]  eDst;
    logic        eBusy;
    logic [1:0]  eGrant;
    logic [31:0] eCnt;
  } vec_t;

  vec_t vecs[13];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nChecks++;
    if (act === exp) nPass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
  endtask

  function automatic int pending();
    int n = 0;
    for (int i = 0; i < NREQ; i++) n += beatQ[i].size();
    return n;
  endfunction

  task automatic addMsg(input int r, input int lenField);
    int len;
    len = (lenField == 0) ? 1 : lenField;
    beatQ[r].push_back({16'($urandom), 16'(lenField)});
    for (int b = 1; b < len; b++) beatQ[r].push_back($urandom);
    lenQ[r].push_back(len);
  endtask

  task automatic doReset();
    RST_N = 1'b0;
    req_src_rdy = '0;
    req_beat = '0;
    msgSource_dst_rdy_b = 1'b0;
    repeat (2) @(posedge CLK);
    #1 RST_N = 1'b1;
    mBusy = 1'b0; mGrant = 0; mPtr = 0; mLeft = 0; mCount = '0;
    grantLog.delete();
    for (int i = 0; i < NREQ; i++) begin
      beatQ[i].delete();
      lenQ[i].delete();
      xferCnt[i] = 0;
    end
  endtask

  // One cycle: drive, compare against the model, then advance the model for the coming edge.
  task automatic stepModel(input int srcPct, input int dstPct);
    logic [NREQ-1:0]    s;
    logic [NREQ*DW-1:0] rb;
    logic               d;
    logic [NREQ-1:0]    eDst;
    logic               eSrc;
    int                 w;
    @(posedge CLK);
    #1;
    for (int i = 0; i < NREQ; i++) begin
      s[i] = (beatQ[i].size() > 0) && (int'($urandom_range(99)) < srcPct);
      rb[i*DW +: DW] = (beatQ[i].size() > 0) ? beatQ[i][0] : $urandom;
    end
    d = int'($urandom_range(99)) < dstPct;
    req_src_rdy = s;
    req_beat = rb;
    msgSource_dst_rdy_b = d;
    #3;
    eSrc = mBusy && s[mGrant];
    eDst = (mBusy && d) ? 4'(1 << mGrant) : 4'b0;
    chk("busy", 32'(busy), 32'(mBusy));
    chk("grant_idx", 32'(grant_idx), 32'(mGrant));
    chk("msg_count", msg_count, mCount);
    chk("src_rdy", 32'(msgSource_src_rdy), 32'(eSrc));
    chk("dst_rdy_b", 32'(req_dst_rdy_b), 32'(eDst));
    if (eSrc) chk("beat", msgSource_beat, beatQ[mGrant][0]);
    if (!mBusy) begin
      w = -1;
      for (int k = 0; k < NREQ; k++)
        if (w < 0 && s[(mPtr + k) % NREQ]) w = (mPtr + k) % NREQ;
      if (w >= 0) begin
        mBusy = 1'b1;
        mGrant = w;
        mLeft = lenQ[w][0];
        grantLog.push_back(w);
      end
    end else if (s[mGrant] && d) begin
      void'(beatQ[mGrant].pop_front());
      xferCnt[mGrant]++;
      mLeft--;
      if (mLeft == 0) begin
        void'(lenQ[mGrant].pop_front());
        mBusy = 1'b0;
        mPtr = (mGrant + 1) % NREQ;
        mCount++;
      end
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int expOrder[5];
    int lf;
    expOrder = '{0, 1, 2, 3, 0};

    // src, b0, b2, dst | eSrc, eBeat, eDst, eBusy, eGrant, eCnt
    vecs[0]  = '{4'b0001, 32'h0000_0003, 32'h0, 1'b1, 1'b0, 32'h0000_0003, 4'b0000, 1'b0, 2'd0, 32'd0};
    vecs[1]  = '{4'b0001, 32'h0000_0003, 32'h0, 1'b1, 1'b1, 32'h0000_0003, 4'b0001, 1'b1, 2'd0, 32'd0};
    vecs[2]  = '{4'b0001, 32'hAAAA_0001, 32'h0, 1'b1, 1'b1, 32'hAAAA_0001, 4'b0001, 1'b1, 2'd0, 32'd0};
    vecs[3]  = '{4'b0001, 32'hBBBB_0002, 32'h0, 1'b1, 1'b1, 32'hBBBB_0002, 4'b0001, 1'b1, 2'd0, 32'd0};
    vecs[4]  = '{4'b0000, 32'h0, 32'h0, 1'b1, 1'b0, 32'h0, 4'b0000, 1'b0, 2'd0, 32'd1};
    vecs[5]  = '{4'b0100, 32'h0, 32'hDEAD_0000, 1'b1, 1'b0, 32'h0, 4'b0000, 1'b0, 2'd0, 32'd1};
    vecs[6]  = '{4'b0100, 32'h0, 32'hDEAD_0000, 1'b1, 1'b1, 32'hDEAD_0000, 4'b0100, 1'b1, 2'd2, 32'd1};
    vecs[7]  = '{4'b0000, 32'h0, 32'h0, 1'b1, 1'b0, 32'h0, 4'b0000, 1'b0, 2'd2, 32'd2};
    vecs[8]  = '{4'b1111, 32'h0000_0001, 32'h0, 1'b1, 1'b0, 32'h0, 4'b0000, 1'b0, 2'd2, 32'd2};
    vecs[9]  = '{4'b1111, 32'h0000_0001, 32'h0, 1'b0, 1'b1, 32'h0000_0001, 4'b0000, 1'b1, 2'd3, 32'd2};
    vecs[10] = '{4'b1111, 32'h0000_0001, 32'h0, 1'b1, 1'b1, 32'h0000_0001, 4'b1000, 1'b1, 2'd3, 32'd2};
    vecs[11] = '{4'b1111, 32'h0000_0001, 32'h0, 1'b1, 1'b0, 32'h0000_0001, 4'b0000, 1'b0, 2'd3, 32'd3};
    vecs[12] = '{4'b1111, 32'h0000_0001, 32'h0, 1'b1, 1'b1, 32'h0000_0001, 4'b0001, 1'b1, 2'd0, 32'd3};

    doReset();
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_count", msg_count, 32'd0);

    for (int v = 0; v < 13; v++) begin
      @(posedge CLK);
      #1;
      req_src_rdy = vecs[v].src;
      req_beat = {32'h0000_0001, vecs[v].b2, 32'h0000_0001, vecs[v].b0};
      msgSource_dst_rdy_b = vecs[v].dst;
      #3;
      chk($sformatf("vec%0d_src_rdy", v), 32'(msgSource_src_rdy), 32'(vecs[v].eSrc));
      chk($sformatf("vec%0d_beat", v), msgSource_beat, vecs[v].eBeat);
      chk($sformatf("vec%0d_dst_rdy_b", v), 32'(req_dst_rdy_b), 32'(vecs[v].eDst));
      chk($sformatf("vec%0d_busy", v), 32'(busy), 32'(vecs[v].eBusy));
      chk($sformatf("vec%0d_grant", v), 32'(grant_idx), 32'(vecs[v].eGrant));
      chk($sformatf("vec%0d_count", v), msg_count, vecs[v].eCnt);
    end

    // All four requesting single-beat messages continuously.
    doReset();
    for (int i = 0; i < NREQ; i++) for (int m = 0; m < 4; m++) addMsg(i, 1);
    for (int c = 0; c < 16; c++) stepModel(100, 100);
    @(posedge CLK);
    #1;
    chk("rr_count_after_16", msg_count, 32'd8);

    // Long 300-beat message from requester 3 while the others keep asking.
    doReset();
    addMsg(0, 1); addMsg(0, 1); addMsg(1, 1); addMsg(2, 1); addMsg(3, 300);
    for (int c = 0; c < 400 && pending() > 0; c++) stepModel(100, 100);
    chk("long_drain", 32'(pending()), 32'd0);
    chk("long_req3_beats", 32'(xferCnt[3]), 32'd300);
    chk("long_grants", 32'(grantLog.size()), 32'd5);
    for (int k = 0; k < 5 && k < grantLog.size(); k++)
      chk($sformatf("long_grant%0d", k), 32'(grantLog[k]), 32'(expOrder[k]));

    // Random traffic with stalls on both sides.
    doReset();
    for (int c = 0; c < 3000; c++) begin
      for (int i = 0; i < NREQ; i++) begin
        if (beatQ[i].size() == 0 && $urandom_range(9) == 0) begin
          lf = int'($urandom_range(99));
          if (lf < 5) lf = 0;
          else if (lf < 10) lf = int'($urandom_range(60, 20));
          else lf = int'($urandom_range(6, 1));
          addMsg(i, lf);
        end
      end
      stepModel(75, 70);
    end

    // Asynchronous reset in the body of a 10-beat message.
    doReset();
    addMsg(0, 10);
    for (int c = 0; c < 30 && xferCnt[0] < 5; c++) stepModel(100, 100);
    @(posedge CLK);
    #2;
    chk("pre_rst_busy", 32'(busy), 32'd1);
    chk("pre_rst_src_rdy", 32'(msgSource_src_rdy), 32'd1);
    RST_N = 1'b0;
    #1;
    chk("arst_busy", 32'(busy), 32'd0);
    chk("arst_src_rdy", 32'(msgSource_src_rdy), 32'd0);
    chk("arst_dst_rdy_b", 32'(req_dst_rdy_b), 32'd0);
    chk("arst_count", msg_count, 32'd0);
    chk("arst_grant", 32'(grant_idx), 32'd0);
    req_src_rdy = 4'b1100;
    req_beat = {32'h0000_0001, 32'h0000_0001, 32'h0, 32'h0};
    @(negedge CLK);
    RST_N = 1'b1;
    @(posedge CLK);
    #1;
    chk("post_rst_grant", 32'(grant_idx), 32'd2);
    chk("post_rst_busy", 32'(busy), 32'd1);
    chk("post_rst_count", msg_count, 32'd0);
    chk("post_rst_dst_rdy_b", 32'(req_dst_rdy_b), 32'b0100);

    $display("%0d/%0d checks passed", nPass, nChecks);
    $finish;
  end

endmodule

// File: doc/portal_msg_arbiter.md
# portal_msg_arbiter

Round-robin arbiter that shares the single simulation message-source channel to the host between NUM_REQ portal message requesters. Each requester presents framed messages as a beat stream using the codebase's `src_rdy`/`dst_rdy`/`beat` handshake. The arbiter grants the channel for a whole message, using the length field in the header beat, then rotates priority. It sits between the portal wrappers and the top-level `msgSource_*` ports that the testbench drains via DPI.

## Interface
- NUM_REQ, 4, number of requesters (2..8)
- DATA_WIDTH, 32, beat width; must be ≥16
- CLK  in  1  clock; all state updates on posedge
- RST_N  in  1  asynchronous, active-low reset
- req_src_rdy  in  NUM_REQ  requester i has a beat valid
- req_beat  in  NUM_REQ*DATA_WIDTH  requester i beat at bits [i*DATA_WIDTH +: DATA_WIDTH]
- req_dst_rdy_b  out  NUM_REQ  beat of requester i accepted this cycle
- msgSource_src_rdy  out  1  output beat valid
- msgSource_beat  out  DATA_WIDTH  output beat
- msgSource_dst_rdy_b  in  1  downstream can accept a beat
- busy  out  1  a grant is held (state ≠ IDLE)
- grant_idx  out  clog2(NUM_REQ)  currently or last granted requester
- msg_count  out  32  messages completed since reset; wraps modulo 2^32

## Operation
- A transfer occurs in any cycle where msgSource_src_rdy & msgSource_dst_rdy_b are both high.
- Header beat: bits [15:0] give the total message length in beats, header included. A length of 0 is treated as 1. Upper bits pass through unmodified.
- States:
  - IDLE:
    - If any req_src_rdy is high, register the winner into grant_idx and go to HDR.
    - Winner is the first set bit scanning from rr_ptr upward, wrapping modulo NUM_REQ.
    - Otherwise stay in IDLE.
  - HDR:
    - On transfer, compute len = max(beat[15:0], 1).
    - If len == 1: message ends (see below), go to IDLE.
    - Else: remaining ← len−1, go to BODY.
  - BODY:
    - On transfer, remaining ← remaining−1.
    - If remaining == 1 at transfer: message ends, go to IDLE.
- Message end: rr_ptr ← (grant_idx+1) mod NUM_REQ; msg_count ← msg_count+1.
- Datapath is combinational pass-through while granted:
  - msgSource_src_rdy = (state≠IDLE) & req_src_rdy[grant_idx]
  - msgSource_beat = req_beat[grant_idx]
  - req_dst_rdy_b[i] = (state≠IDLE) & (i==grant_idx) & msgSource_dst_rdy_b
  - All other req_dst_rdy_b bits are 0.
- Ungranted requesters are never acknowledged, so their beats are held by their senders.
- A granted requester dropping src_rdy mid-message stalls the channel. There is no timeout, and the grant is held until the message completes.
- remaining is 16 bits wide; a length of 65535 is legal.

## Timing
- Reset (RST_N low, asynchronous): state=IDLE, rr_ptr=0, grant_idx=0, remaining=0, msg_count=0.
- Output values during reset: msgSource_src_rdy=0, req_dst_rdy_b=0, busy=0. msgSource_beat follows req_beat[0].
- Reset asserted mid-message: the message is abandoned immediately. After release, arbitration restarts from requester 0. A partially sent message is not resumed.
- Arbitration latency: requester raises src_rdy in cycle t while IDLE → grant registered at the t+1 edge → header can transfer in cycle t+1.
- Back-to-back messages: one IDLE bubble cycle between the last beat of one message and the header of the next.
- Steady-state throughput within a message: 1 beat/cycle while both sides are ready.
- Simultaneous requests: all eligible requesters are served in rotating order before any requester is served twice.
- Length wrap: message-end detection depends only on remaining. Header bits [31:16] never affect control.

## Test plan
- Single requester 0 sends header 0x0000_0003 plus 2 body beats, downstream always ready → three consecutive transfers starting 1 cycle after src_rdy. msg_count=1, busy drops the cycle after the last beat.
- All 4 requesters continuously request 1-beat messages (header 0x0001) → grant order 0,1,2,3,0,… with a message every 2 cycles; msg_count=8 after 16 cycles.
- Header length 0 from requester 2 → treated as 1 beat; FSM returns to IDLE after one transfer and rr_ptr=3.
- Requester 1 sends a 4-beat message; msgSource_dst_rdy_b is held low for 3 cycles mid-body and src_rdy drops for 2 cycles → no beat lost or duplicated. Requester 0 is never acknowledged during this message, and the beats appear in order.
- Reset asserted asynchronously (mid-cycle) during the BODY of a 10-beat message after 5 beats → outputs clear immediately. After release with requesters 2 and 3 pending, requester 2 is granted first and msg_count=0.
- Requester 3 sends a 300-beat message (header 0x012C) while the others request → exactly 300 contiguous transfers from requester 3 and no interleaving; the next grant goes to requester 0.
